spi_shader_loader: RTL and testbench

- Parametrised SPI target (mode 0, MSB first) that loads and reads back the shader instruction memory over the bidir PMOD SPI pins.
- Replaces fixed-width sequential-only loading with:
  - a command byte,
  - a settable start address,
  - a MISO read-back path,
  - parametrised instruction width and memory depth.
- Sits between the top-level uio pins (cs, mosi, miso, sclk) and the shader memory write/read port.
- Runs entirely in the system clock domain.

---
 rtl/tiny_shader_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_shader_loader.sv | 194 +++++++++++++++++++
 tb/tb_spi_shader_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_shader_pkg.sv
// Shared definitions for the SPI shader loader: command opcodes and the
// loader state encoding.
package tiny_shader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WADDR,
        RADDR,
        WRITE,
        READ,
        IGNORE
    } loader_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin with edge pulses.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   din       - asynchronous input pin
//   q         - synchronised level
//   rise/fall - one-clk pulses on synchronised 0->1 / 1->0 transitions
// The chain resets to 0, so a pin already low when reset releases produces
// no fall pulse; only a genuine high-to-low transition afterwards does.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], din};
            prev_q <= sync_p[SYNC_STAGES-1];
        end
    end

    assign q    = sync_p[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_shader_loader.sv
// SPI mode-0 target (MSB first) that loads and reads back the shader
// instruction memory. Transaction: command byte (0x01 write, 0x02 read),
// start-address byte, then a stream of INSTR_WIDTH-bit words.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   spi_cs_i          - chip select, active-low, asynchronous
//   spi_sclk_i        - SPI clock, asynchronous
//   spi_mosi_i        - SPI data in, asynchronous
//   spi_miso_o        - SPI data out (0 outside READ)
//   mem_we_o          - one-clk write strobe
//   mem_addr_o        - memory address (write and read)
//   mem_wdata_o       - write data
//   mem_rdata_i       - read data, valid 1 clk after mem_addr_o changes
//   busy_o            - high while a transaction is in progress
//   load_done_o       - one-clk pulse at CS release after >= 1 committed write
module spi_shader_loader
    import tiny_shader_pkg::*;
#(
    parameter int INSTR_WIDTH = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_cs_i,
    input  logic                   spi_sclk_i,
    input  logic                   spi_mosi_i,
    output logic                   spi_miso_o,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [INSTR_WIDTH-1:0] mem_wdata_o,
    input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
    output logic                   busy_o,
    output logic                   load_done_o
);

    // Receive register is wide enough for both the 8-bit command/address
    // bytes and a full instruction word.
    localparam int         RX_W      = (INSTR_WIDTH > 8) ? INSTR_WIDTH : 8;
    localparam logic [4:0] BYTE_LAST = 5'd7;
    localparam logic [4:0] WORD_LAST = 5'(INSTR_WIDTH - 1);

    loader_state_t state, state_next;

    logic [3:0]             sync_unused;
    logic                   cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
    logic [RX_W-2:0]        rx_q;
    logic [RX_W-1:0]        rx_next;
    logic [4:0]             bit_cnt, tx_cnt;
    logic [INSTR_WIDTH-1:0] tx_q, tx_src;
    logic [1:0]             pf_cnt;
    logic [ADDR_WIDTH-1:0]  ptr;
    logic                   wrote_any;
    logic                   shift_en, bit_last, word_done, tx_last, pf_load;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rst(rst), .din(spi_cs_i),
        .q(sync_unused[0]), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk_i),
        .q(sync_unused[1]), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi_i),
        .q(mosi_s), .rise(sync_unused[2]), .fall(sync_unused[3])
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rx_next    = {rx_q, mosi_s};
        bit_last   = 1'b0;
        case (state)
            CMD, WADDR, RADDR: bit_last = (bit_cnt == BYTE_LAST);
            WRITE:             bit_last = (bit_cnt == WORD_LAST);
            default:           bit_last = 1'b0;
        endcase
        shift_en  = sclk_rise && (state inside {CMD, WADDR, RADDR, WRITE});
        word_done = shift_en && bit_last;
        tx_last   = (tx_cnt == WORD_LAST);
        // pf_cnt == 1 marks the clk in which mem_rdata_i reflects the
        // prefetch address; a coinciding sclk fall takes the data directly.
        pf_load   = (pf_cnt == 2'd1);
        tx_src    = pf_load ? mem_rdata_i : tx_q;

        // CS release overrides everything, including a final data bit
        // arriving in the same clk.
        if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) state_next = CMD;
                CMD: begin
                    if (word_done) begin
                        case (rx_next[7:0])
                            CMD_WRITE: state_next = WADDR;
                            CMD_READ:  state_next = RADDR;
                            default:   state_next = IGNORE;
                        endcase
                    end
                end
                WADDR: if (word_done) state_next = WRITE;
                RADDR: if (word_done) state_next = READ;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q        <= '0;
            bit_cnt     <= '0;
            tx_cnt      <= '0;
            tx_q        <= '0;
            pf_cnt      <= '0;
            ptr         <= '0;
            wrote_any   <= 1'b0;
            spi_miso_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            load_done_o <= 1'b0;
        end else begin
            mem_we_o    <= 1'b0;
            load_done_o <= 1'b0;
            if (cs_rise) begin
                // Any partial word is dropped simply by clearing the counters.
                busy_o      <= 1'b0;
                spi_miso_o  <= 1'b0;
                bit_cnt     <= '0;
                tx_cnt      <= '0;
                pf_cnt      <= '0;
                load_done_o <= wrote_any;
                wrote_any   <= 1'b0;
            end else begin
                if (cs_fall) begin
                    busy_o  <= 1'b1;
                    bit_cnt <= '0;
                end
                if (shift_en) begin
                    rx_q    <= rx_next[RX_W-2:0];
                    bit_cnt <= bit_last ? 5'd0 : bit_cnt + 5'd1;
                end
                if (word_done) begin
                    case (state)
                        WADDR: ptr <= rx_next[ADDR_WIDTH-1:0];
                        RADDR: begin
                            ptr        <= rx_next[ADDR_WIDTH-1:0];
                            mem_addr_o <= rx_next[ADDR_WIDTH-1:0];
                            pf_cnt     <= 2'd2;
                            tx_cnt     <= '0;
                        end
                        WRITE: begin
                            mem_wdata_o <= rx_next[INSTR_WIDTH-1:0];
                            mem_addr_o  <= ptr;
                            mem_we_o    <= 1'b1;
                            ptr         <= ptr + ADDR_WIDTH'(1);
                            wrote_any   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (state == READ) begin
                    if (pf_cnt != 2'd0) pf_cnt <= pf_cnt - 2'd1;
                    if (pf_load)        tx_q   <= mem_rdata_i;
                    if (sclk_fall) begin
                        spi_miso_o <= tx_src[INSTR_WIDTH-1];
                        tx_q       <= tx_src << 1;
                        if (tx_last) begin
                            // Word fully shifted out: advance and prefetch
                            // the next one well before the next fall.
                            tx_cnt     <= '0;
                            ptr        <= ptr + ADDR_WIDTH'(1);
                            mem_addr_o <= ptr + ADDR_WIDTH'(1);
                            pf_cnt     <= 2'd2;
                        end else begin
                            tx_cnt <= tx_cnt + 5'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_shader_loader.sv
module tb_spi_shader_loader;

    localparam int HP = 5;  // SCLK half-period in clk cycles

    logic clk, rst;
    logic cs_a, cs_b, sclk, mosi;
    logic miso_a, we_a, busy_a, ld_a;
    logic [3:0] addr_a;
    logic [7:0] wdata_a, rdata_a;
    logic miso_b, we_b, busy_b, ld_b;
    logic [4:0] addr_b;
    logic [11:0] wdata_b, rdata_b;

    spi_shader_loader #(.INSTR_WIDTH(8), .MEM_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .spi_cs_i(cs_a), .spi_sclk_i(sclk),
        .spi_mosi_i(mosi), .spi_miso_o(miso_a), .mem_we_o(we_a),
        .mem_addr_o(addr_a), .mem_wdata_o(wdata_a), .mem_rdata_i(rdata_a),
        .busy_o(busy_a), .load_done_o(ld_a)
    );

    spi_shader_loader #(.INSTR_WIDTH(12), .MEM_DEPTH(32)) dut_b (
        .clk(clk), .rst(rst), .spi_cs_i(cs_b), .spi_sclk_i(sclk),
        .spi_mosi_i(mosi), .spi_miso_o(miso_b), .mem_we_o(we_b),
        .mem_addr_o(addr_b), .mem_wdata_o(wdata_b), .mem_rdata_i(rdata_b),
        .busy_o(busy_b), .load_done_o(ld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models and write / load_done logs
    logic [7:0]  mem_a [16];
    logic [11:0] mem_b [32];
    logic [15:0] la_addr [128];
    logic [15:0] la_data [128];
    logic [15:0] lb_addr [128];
    logic [15:0] lb_data [128];
    int wcnt_a = 0, wcnt_b = 0, ldc_a = 0, ldc_b = 0;

    always @(posedge clk) begin
        rdata_a <= mem_a[addr_a];
        rdata_b <= mem_b[addr_b];
        if (we_a) begin
            mem_a[addr_a]        <= wdata_a;
            la_addr[wcnt_a[6:0]] <= {12'h0, addr_a};
            la_data[wcnt_a[6:0]] <= {8'h0, wdata_a};
            wcnt_a               <= wcnt_a + 1;
        end
        if (we_b) begin
            mem_b[addr_b]        <= wdata_b;
            lb_addr[wcnt_b[6:0]] <= {11'h0, addr_b};
            lb_data[wcnt_b[6:0]] <= {4'h0, wdata_b};
            wcnt_b               <= wcnt_b + 1;
        end
        if (ld_a) ldc_a <= ldc_a + 1;
        if (ld_b) ldc_b <= ldc_b + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of val MSB first; capture MISO just before each rise.
    task automatic xfer(input logic sel, input logic [15:0] val, input int nbits,
                        output logic [15:0] rxv);
        rxv = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = val[i];
            clks(HP);
            rxv  = {rxv[14:0], (sel ? miso_b : miso_a)};
            sclk = 1'b1;
            clks(HP);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low(input logic sel);
        if (sel) cs_b = 1'b0;
        else     cs_a = 1'b0;
        clks(HP);
    endtask

    task automatic cs_high();
        clks(HP);
        cs_a = 1'b1;
        cs_b = 1'b1;
        clks(8);
    endtask

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [2:0]  n;
        logic [31:0] d;
        logic [2:0]  exp_n;
        logic [15:0] exp_a;
        logic        exp_ld;
    } vec_t;

    vec_t vecs [5];
    logic [15:0] r, mor;
    int base, ldb;

    initial begin
        vecs[0] = '{8'h01, 8'h0E, 3'd4, 32'hA0A1A2A3, 3'd4, 16'hEF01, 1'b1}; // wrap
        vecs[1] = '{8'h7E, 8'h11, 3'd2, 32'h22330000, 3'd0, 16'h0000, 1'b0}; // bad cmd
        vecs[2] = '{8'h01, 8'h00, 3'd1, 32'h55000000, 3'd1, 16'h0000, 1'b1};
        vecs[3] = '{8'h01, 8'hF3, 3'd1, 32'h66000000, 3'd1, 16'h3000, 1'b1}; // high addr bits
        vecs[4] = '{8'h01, 8'h05, 3'd0, 32'h00000000, 3'd0, 16'h0000, 1'b0}; // no word

        cs_a = 1'b1; cs_b = 1'b1; sclk = 1'b0; mosi = 1'b0; rst = 1'b1;
        clks(5);
        chk("reset miso_a", 32'(miso_a), 0);
        chk("reset we_a", 32'(we_a), 0);
        chk("reset addr_a", 32'(addr_a), 0);
        chk("reset wdata_a", 32'(wdata_a), 0);
        chk("reset busy_a", 32'(busy_a), 0);
        chk("reset ld_a", 32'(ld_a), 0);
        chk("reset outs_b", 32'({miso_b, we_b, addr_b, wdata_b, busy_b, ld_b}), 0);
        rst = 1'b0;
        clks(6);

        // Burst of 16 words from address 0
        base = wcnt_a; ldb = ldc_a;
        cs_low(0);
        chk("burst busy", 32'(busy_a), 1);
        xfer(0, 16'h01, 8, r);
        xfer(0, 16'h00, 8, r);
        for (int i = 0; i < 16; i++) xfer(0, 16'(8'h10 + i), 8, r);
        cs_high();
        chk("burst wcount", 32'(wcnt_a - base), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst addr%0d", i), 32'(la_addr[base + i]), 32'(i));
            chk($sformatf("burst data%0d", i), 32'(la_data[base + i]), 32'(8'h10 + i));
        end
        chk("burst load_done", 32'(ldc_a - ldb), 1);
        chk("burst busy end", 32'(busy_a), 0);

        // Table-driven transactions
        for (int v = 0; v < 5; v++) begin
            base = wcnt_a; ldb = ldc_a; mor = '0;
            cs_low(0);
            xfer(0, {8'h0, vecs[v].cmd}, 8, r);  mor |= r;
            xfer(0, {8'h0, vecs[v].addr}, 8, r); mor |= r;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                xfer(0, {8'h0, vecs[v].d[31 - 8*i -: 8]}, 8, r);
                mor |= r;
            end
            cs_high();
            chk($sformatf("v%0d wcount", v), 32'(wcnt_a - base), 32'(vecs[v].exp_n));
            for (int i = 0; i < int'(vecs[v].exp_n); i++) begin
                chk($sformatf("v%0d addr%0d", v, i), 32'(la_addr[base + i]),
                    32'(vecs[v].exp_a[15 - 4*i -: 4]));
                chk($sformatf("v%0d data%0d", v, i), 32'(la_data[base + i]),
                    32'(vecs[v].d[31 - 8*i -: 8]));
            end
            chk($sformatf("v%0d load_done", v), 32'(ldc_a - ldb), 32'(vecs[v].exp_ld));
            chk($sformatf("v%0d miso", v), 32'(mor), 0);
        end

        // Abort after 5 data bits, then a clean write at 0x03
        base = wcnt_a; ldb = ldc_a;
        cs_low(0);
        xfer(0, 16'h01, 8, r);
        xfer(0, 16'h03, 8, r);
        xfer(0, 16'h15, 5, r);
        cs_high();
        chk("abort wcount", 32'(wcnt_a - base), 0);
        chk("abort load_done", 32'(ldc_a - ldb), 0);
        chk("abort busy", 32'(busy_a), 0);
        cs_low(0);
        xfer(0, 16'h01, 8, r);
        xfer(0, 16'h03, 8, r);
        xfer(0, 16'h77, 8, r);
        cs_high();
        chk("after abort wcount", 32'(wcnt_a - base), 1);
        chk("after abort addr", 32'(la_addr[base]), 3);
        chk("after abort data", 32'(la_data[base]), 32'h77);

        // CS release in the same clk as the final SCLK rise
        base = wcnt_a; ldb = ldc_a;
        cs_low(0);
        xfer(0, 16'h01, 8, r);
        xfer(0, 16'h07, 8, r);
        xfer(0, 16'h26, 7, r);
        mosi = 1'b1;
        clks(HP);
        sclk = 1'b1;
        cs_a = 1'b1;
        clks(HP);
        sclk = 1'b0;
        clks(8);
        chk("cs race wcount", 32'(wcnt_a - base), 0);
        chk("cs race load_done", 32'(ldc_a - ldb), 0);

        // Preload 0xC0+n, then read back from address 5
        cs_low(0);
        xfer(0, 16'h01, 8, r);
        xfer(0, 16'h00, 8, r);
        for (int i = 0; i < 16; i++) xfer(0, 16'(8'hC0 + i), 8, r);
        cs_high();
        base = wcnt_a; ldb = ldc_a; mor = '0;
        cs_low(0);
        xfer(0, 16'h02, 8, r); mor |= r;
        xfer(0, 16'h05, 8, r); mor |= r;
        chk("read hdr miso", 32'(mor), 0);
        xfer(0, 16'h00, 8, r);
        chk("read word0", 32'(r), 32'hC5);
        xfer(0, 16'h00, 8, r);
        chk("read word1", 32'(r), 32'hC6);
        xfer(0, 16'h00, 8, r);
        chk("read word2", 32'(r), 32'hC7);
        cs_high();
        chk("read wcount", 32'(wcnt_a - base), 0);
        chk("read load_done", 32'(ldc_a - ldb), 0);
        chk("read miso idle", 32'(miso_a), 0);

        // 12-bit / 32-deep instance with wrap
        base = wcnt_b; ldb = ldc_b;
        cs_low(1);
        xfer(1, 16'h01, 8, r);
        xfer(1, 16'h1F, 8, r);
        xfer(1, 16'hABC, 12, r);
        xfer(1, 16'h123, 12, r);
        cs_high();
        chk("w12 wcount", 32'(wcnt_b - base), 2);
        chk("w12 addr0", 32'(lb_addr[base]), 31);
        chk("w12 data0", 32'(lb_data[base]), 32'hABC);
        chk("w12 addr1", 32'(lb_addr[base + 1]), 0);
        chk("w12 data1", 32'(lb_data[base + 1]), 32'h123);
        chk("w12 load_done", 32'(ldc_b - ldb), 1);

        // Reset mid-word
        base = wcnt_b; ldb = ldc_b;
        cs_low(1);
        xfer(1, 16'h01, 8, r);
        xfer(1, 16'h05, 8, r);
        xfer(1, 16'h456, 12, r);
        xfer(1, 16'h789 >> 6, 6, r);
        rst = 1'b1;
        clks(1);
        chk("rst addr_b", 32'(addr_b), 0);
        chk("rst wdata_b", 32'(wdata_b), 0);
        chk("rst ctl_b", 32'({miso_b, we_b, busy_b, ld_b}), 0);
        clks(2);
        rst = 1'b0;
        clks(2);
        xfer(1, 16'h789 & 16'h3F, 6, r);
        cs_high();
        chk("rst wcount", 32'(wcnt_b - base), 1);
        chk("rst pre-word addr", 32'(lb_addr[base]), 5);
        chk("rst pre-word data", 32'(lb_data[base]), 32'h456);
        chk("rst load_done", 32'(ldc_b - ldb), 0);
        base = wcnt_b; ldb = ldc_b;
        cs_low(1);
        xfer(1, 16'h01, 8, r);
        xfer(1, 16'h09, 8, r);
        xfer(1, 16'h0F0, 12, r);
        cs_high();
        chk("post-rst wcount", 32'(wcnt_b - base), 1);
        chk("post-rst addr", 32'(lb_addr[base]), 9);
        chk("post-rst data", 32'(lb_data[base]), 32'h0F0);
        chk("post-rst load_done", 32'(ldc_b - ldb), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
